// File: rtl/little_cpu_pkg.sv
// Shared types and default widths for the little CPU memory-side blocks.
package little_cpu_pkg;

  localparam int DEF_BITS      = 16;
  localparam int DEF_ADDR_BITS = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/mem_array.sv
// DEPTH x BITS storage: synchronous write, registered read port whose output
// register holds its value until the next read or clear.
module mem_array #(
  parameter int BITS     = 16,
  parameter int DEPTH    = 256,
  parameter int IDX_BITS = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_we,
  input  logic                i_re,
  input  logic                i_clr,
  input  logic [IDX_BITS-1:0] i_addr,
  input  logic [BITS-1:0]     i_wdata,
  output logic [BITS-1:0]     o_rdata
);

  logic [BITS-1:0] mem [DEPTH];
  logic [BITS-1:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (i_clr)     rdata_d = '0;
    else if (i_re) rdata_d = mem[i_addr];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

  // Storage is deliberately not cleared by reset.
  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_addr] <= i_wdata;
  end

  assign o_rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: accept, WAIT_STATES wait cycles, one-cycle
// ack. Out-of-range addresses are flagged with o_err and never touch storage.
module mem_responder
  import little_cpu_pkg::*;
#(
  parameter int BITS        = DEF_BITS,
  parameter int ADDR_BITS   = DEF_ADDR_BITS,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_req,
  input  logic                 i_we,
  input  logic [ADDR_BITS-1:0] i_addr,
  input  logic [BITS-1:0]      i_data,
  output logic                 o_ack,
  output logic [BITS-1:0]      o_data,
  output logic                 o_busy,
  output logic                 o_err
);

  localparam int IDX_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   we_q, we_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [BITS-1:0]        data_q, data_d;

  logic                   eff_we;
  logic [ADDR_BITS-1:0]   eff_addr;
  logic [BITS-1:0]        eff_data;
  logic                   eff_in_range;
  logic                   enter_resp;
  logic                   mem_we, mem_re, mem_clr;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (i_req) begin
          we_d   = i_we;
          addr_d = i_addr;
          data_d = i_data;
          if (WAIT_STATES == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_STATES);
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = RESP;
          cnt_d   = 4'd0;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With zero wait states RESP is entered on the accept edge itself, so the
  // storage access must use the live request rather than the latched copy.
  always_comb begin
    eff_we       = (state_q == IDLE) ? i_we   : we_q;
    eff_addr     = (state_q == IDLE) ? i_addr : addr_q;
    eff_data     = (state_q == IDLE) ? i_data : data_q;
    eff_in_range = 32'(eff_addr) < DEPTH;
    enter_resp   = (state_d == RESP) && (state_q != RESP) && !i_rst;
    mem_we       = enter_resp && eff_in_range && eff_we;
    mem_re       = enter_resp && eff_in_range && !eff_we;
    mem_clr      = enter_resp && !eff_in_range && !eff_we;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  mem_array #(
    .BITS     (BITS),
    .DEPTH    (DEPTH),
    .IDX_BITS (IDX_BITS)
  ) u_mem (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_we    (mem_we),
    .i_re    (mem_re),
    .i_clr   (mem_clr),
    .i_addr  (eff_addr[IDX_BITS-1:0]),
    .i_wdata (eff_data),
    .o_rdata (o_data)
  );

  assign o_ack  = (state_q == RESP);
  assign o_busy = (state_q != IDLE);
  assign o_err  = o_ack && !(32'(addr_q) < DEPTH);

endmodule
